// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one MMU burst-read port between I$ and D$ refills,
// with beat steering to the grant owner and burst-length checking.
module cache_mem_arbiter #(
    parameter int BURST_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_read_req,
    input  logic [31:0] inst_addr_mmu,
    output logic        inst_addr_ok,
    output logic [31:0] inst_read_data,
    output logic        inst_valid,
    output logic        inst_last,
    input  logic        data_read_req,
    input  logic [31:0] data_addr_mmu,
    output logic        data_addr_ok,
    output logic [31:0] data_read_data,
    output logic        data_valid,
    output logic        data_last,
    output logic [31:0] mem_addr,
    output logic        mem_read_req,
    input  logic        mem_addr_ok,
    input  logic [31:0] mem_read_data,
    input  logic        mem_valid,
    input  logic        mem_last,
    output logic        busy,
    output logic        owner,
    output logic        burst_err
);
    localparam int W = $clog2(BURST_LEN);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t       state;
    logic [31:0]  addr_q;
    logic [W-1:0] beat_cnt;
    logic         pick, in_addr, in_data, cnt_end;
    // owner is also the round-robin history: a tie goes to the client not granted last
    assign pick    = (inst_read_req && data_read_req) ? !owner : data_read_req;
    assign in_addr = state == ADDR;
    assign in_data = state == DATA;
    assign cnt_end = beat_cnt == W'(BURST_LEN - 1);
    assign busy         = state != IDLE;
    assign mem_read_req = in_addr;
    assign mem_addr     = in_addr ? addr_q : '0;
    assign inst_addr_ok   = in_addr && !owner && mem_addr_ok;
    assign data_addr_ok   = in_addr && owner && mem_addr_ok;
    assign inst_valid     = in_data && !owner && mem_valid;
    assign data_valid     = in_data && owner && mem_valid;
    assign inst_last      = inst_valid && mem_last;
    assign data_last      = data_valid && mem_last;
    assign inst_read_data = (in_data && !owner) ? mem_read_data : '0;
    assign data_read_data = (in_data && owner) ? mem_read_data : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            addr_q    <= '0;
            beat_cnt  <= '0;
            burst_err <= 1'b0;
        end else begin
            burst_err <= 1'b0;
            case (state)
                IDLE: if (inst_read_req || data_read_req) begin
                    owner    <= pick;
                    addr_q   <= pick ? data_addr_mmu : inst_addr_mmu;
                    beat_cnt <= '0;
                    state    <= ADDR;
                end
                ADDR: if (mem_addr_ok) state <= DATA;
                DATA: if (mem_valid) begin
                    beat_cnt  <= beat_cnt + 1'b1;
                    burst_err <= mem_last ? !cnt_end : cnt_end;
                    if (mem_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: table-driven burst scenarios with a beat scoreboard, plus hand-written
// stray-beat and reset corner cases.
module tb_cache_mem_arbiter;
    logic        clk = 0, rst = 1;
    logic        inst_read_req = 0, data_read_req = 0;
    logic [31:0] inst_addr_mmu = 0, data_addr_mmu = 0;
    logic        inst_addr_ok, inst_valid, inst_last, data_addr_ok, data_valid, data_last;
    logic [31:0] inst_read_data, data_read_data, mem_addr;
    logic        mem_read_req, mem_addr_ok = 0, mem_valid = 0, mem_last = 0;
    logic [31:0] mem_read_data = 0;
    logic        busy, owner, burst_err;
    int checks = 0, errors = 0;
    logic [67:0] sb[$];

    typedef struct {
        logic        do_rst, ireq, dreq;
        logic [31:0] iaddr, daddr;
        logic        own;
        logic [31:0] addr;
        int          ok_dly, n;
        logic [31:0] base;
        logic        err;
        int          wait_c;
        logic        hold;
        int          rst_beat;
    } vec_t;
    vec_t vecs[10];

    cache_mem_arbiter #(.BURST_LEN(16)) dut (
        .clk(clk), .rst(rst),
        .inst_read_req(inst_read_req), .inst_addr_mmu(inst_addr_mmu), .inst_addr_ok(inst_addr_ok),
        .inst_read_data(inst_read_data), .inst_valid(inst_valid), .inst_last(inst_last),
        .data_read_req(data_read_req), .data_addr_mmu(data_addr_mmu), .data_addr_ok(data_addr_ok),
        .data_read_data(data_read_data), .data_valid(data_valid), .data_last(data_last),
        .mem_addr(mem_addr), .mem_read_req(mem_read_req), .mem_addr_ok(mem_addr_ok),
        .mem_read_data(mem_read_data), .mem_valid(mem_valid), .mem_last(mem_last),
        .busy(busy), .owner(owner), .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {inst_addr_ok, inst_valid, inst_last, inst_read_data, data_addr_ok, data_valid,
                 data_last, data_read_data, mem_addr, mem_read_req, busy, owner, burst_err}, '0);
    endtask

    task automatic do_burst(input vec_t v);
        int k = 0;
        logic dead = 0;
        logic [67:0] e, a;
        while (!mem_read_req && k < 20) begin
            tick();
            #1;
            k++;
        end
        chk("grant_wait", k, v.wait_c);
        chk("mem_addr", mem_addr, v.addr);
        chk("owner", owner, v.own);
        chk("busy", busy, 1);
        for (int d = 1; d < v.ok_dly; d++) begin
            tick();
            #1;
            chk("addr_ok_early", {inst_addr_ok, data_addr_ok}, 0);
        end
        tick();
        mem_addr_ok = 1;
        #1;
        chk("addr_ok", {inst_addr_ok, data_addr_ok}, v.own ? 2'b01 : 2'b10);
        tick();
        mem_addr_ok = 0;
        if (!v.hold) begin
            if (v.own) data_read_req = 0;
            else inst_read_req = 0;
        end
        for (int i = 0; i < v.n; i++) begin
            if (i > 0) tick();
            mem_valid = 1;
            mem_read_data = v.base + i;
            mem_last = (i == v.n - 1);
            rst = (i == v.rst_beat);
            if (rst) dead = 1;
            e = dead ? '0 : v.own ? {34'b0, 1'b1, mem_last, mem_read_data}
                                  : {1'b1, mem_last, mem_read_data, 34'b0};
            sb.push_back(e);
            #1;
            a = {inst_valid, inst_last, inst_read_data, data_valid, data_last, data_read_data};
            chk("beat", a, sb.pop_front());
            if (rst) chk_zero("reset_mid");
        end
        tick();
        mem_valid = 0;
        mem_last = 0;
        rst = 0;
        #1;
        chk("burst_err", burst_err, v.err);
        chk("turnaround", {busy, mem_read_req}, 0);
        tick();
        #1;
        chk("burst_err_clr", burst_err, 0);
    endtask

    initial begin
        vecs[0] = '{0, 1, 0, 32'h1FC0_0040, 0, 0, 32'h1FC0_0040, 3, 16, 32'h100, 0, 1, 0, -1};
        vecs[1] = '{1, 1, 1, 32'h1000, 32'h2000, 1, 32'h2000, 1, 16, 32'h200, 0, 1, 0, -1};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 32'h1000, 1, 16, 32'h300, 0, 0, 0, -1};
        vecs[3] = '{0, 1, 1, 32'h3000, 32'h4000, 1, 32'h4000, 2, 16, 32'h400, 0, 1, 1, -1};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 32'h3000, 2, 16, 32'h500, 0, 0, 1, -1};
        vecs[5] = '{0, 0, 0, 0, 0, 1, 32'h4000, 2, 16, 32'h600, 0, 0, 1, -1};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 32'h3000, 2, 16, 32'h700, 0, 0, 0, -1};
        vecs[7] = '{0, 0, 0, 0, 0, 1, 32'h4000, 1, 12, 32'h800, 1, 0, 0, -1};
        vecs[8] = '{0, 0, 1, 0, 32'h5000, 1, 32'h5000, 1, 16, 32'h900, 0, 1, 0, 6};
        vecs[9] = '{0, 1, 0, 32'h6000, 0, 0, 32'h6000, 1, 16, 32'hA00, 0, 1, 0, -1};
        #1;
        chk_zero("reset_state");
        tick();
        rst = 0;
        #1;
        for (int t = 0; t < 10; t++) begin
            if (vecs[t].do_rst) begin
                rst = 1;
                #1;
                chk_zero("reset_again");
                tick();
                rst = 0;
                #1;
            end
            if (vecs[t].ireq) begin
                inst_read_req = 1;
                inst_addr_mmu = vecs[t].iaddr;
            end
            if (vecs[t].dreq) begin
                data_read_req = 1;
                data_addr_mmu = vecs[t].daddr;
            end
            do_burst(vecs[t]);
        end
        mem_valid = 1;
        mem_last = 1;
        mem_read_data = 32'hDEAD;
        inst_read_req = 1;
        inst_addr_mmu = 32'h7000;
        #1;
        chk("stray_idle", {inst_valid, data_valid, inst_last, data_last}, 0);
        tick();
        #1;
        chk("stray_addr", {inst_valid, data_valid, mem_read_req}, 3'b001);
        tick();
        #1;
        chk("stray_addr_hold", {inst_valid, data_valid, busy, mem_read_req}, 4'b0011);
        mem_valid = 0;
        mem_last = 0;
        do_burst('{0, 0, 0, 0, 0, 0, 32'h7000, 1, 16, 32'hB00, 0, 0, 0, -1});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
